// File: rtl/apb_uart_master.sv
// apb_uart_master: UART command frames replayed as APB master transfers, with a status/read-data reply on tx
module apb_uart_master #(
    parameter int CLKS_PER_BIT   = 434,
    parameter int APB_ADDR_WIDTH = 8,
    parameter int APB_DATA_WIDTH = 32,
    parameter int FRAME_TIMEOUT  = 1000000,
    parameter int PREADY_TIMEOUT = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx,
    output logic                      tx,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [APB_ADDR_WIDTH-1:0] paddr,
    output logic [APB_DATA_WIDTH-1:0] pwdata,
    input  logic [APB_DATA_WIDTH-1:0] prdata,
    input  logic                      pready,
    input  logic                      pslverr,
    output logic                      busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int FW = $clog2(FRAME_TIMEOUT + 1);
    localparam int AW = $clog2(PREADY_TIMEOUT + 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [3:0] {P_IDLE, P_ADDR, P_DATA0, P_DATA1, P_DATA2, P_DATA3,
                              APB_SETUP, APB_ACCESS, RESP} p_state_t;

    rx_state_t rx_state, rx_next;
    p_state_t  p_state, p_next;
    logic rx_s1, rx_s2, rx_q, rx_valid, rx_err;
    logic [CW-1:0] rx_cnt, tx_cnt;
    logic [2:0] rx_bit, tx_left;
    logic [3:0] tx_bit;
    logic [7:0] rx_shift;
    logic [FW-1:0] to_cnt;
    logic [AW-1:0] acc_cnt;
    logic [APB_DATA_WIDTH+7:0] resp_buf;
    logic [9:0] tx_frame;
    logic rx_mid, rx_end, tx_bit_end, in_frame, frame_to, acc_to;

    assign rx_mid     = rx_cnt == CW'(CLKS_PER_BIT / 2 - 1);
    assign rx_end     = rx_cnt == CW'(CLKS_PER_BIT - 1);
    assign tx_bit_end = tx_cnt == CW'(CLKS_PER_BIT - 1);
    assign in_frame   = p_state inside {P_ADDR, P_DATA0, P_DATA1, P_DATA2, P_DATA3};
    assign frame_to   = to_cnt == FW'(FRAME_TIMEOUT);
    assign acc_to     = acc_cnt == AW'(PREADY_TIMEOUT - 1);
    assign tx_frame   = {1'b1, resp_buf[7:0], 1'b0};
    assign psel       = p_state == APB_SETUP || p_state == APB_ACCESS;
    assign penable    = p_state == APB_ACCESS;
    assign busy       = p_state != P_IDLE;
    assign tx         = p_state == RESP ? tx_frame[tx_bit] : 1'b1;

    // two-flop synchronizer plus one delayed copy for start-edge detection
    always_ff @(posedge clk or posedge reset)
        if (reset) {rx_s1, rx_s2, rx_q} <= 3'b111;
        else       {rx_s1, rx_s2, rx_q} <= {rx, rx_s1, rx_s2};

    // state registers for the receiver and the frame parser
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            rx_state <= R_IDLE;
            p_state  <= P_IDLE;
        end else begin
            rx_state <= rx_next;
            p_state  <= p_next;
        end

    // receiver sequencing: start re-check at mid-bit, then eight data bits and the stop bit
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            R_IDLE:  if (rx_q && !rx_s2) rx_next = R_START;
            R_START: if (rx_mid) rx_next = rx_s2 ? R_IDLE : R_DATA;
            R_DATA:  if (rx_end && rx_bit == 3'd7) rx_next = R_STOP;
            R_STOP:  if (rx_end) rx_next = R_IDLE;
            default: rx_next = R_IDLE;
        endcase
    end

    // receiver datapath: bit timing, LSB-first shift, byte/framing-error strobes
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            rx_valid <= rx_state == R_STOP && rx_end && rx_s2;
            rx_err   <= rx_state == R_STOP && rx_end && !rx_s2;
            rx_cnt   <= (rx_state == R_IDLE || rx_end || (rx_state == R_START && rx_mid)) ? '0 : rx_cnt + 1'b1;
            if (rx_state == R_DATA && rx_end) begin
                rx_shift <= {rx_s2, rx_shift[7:1]};
                rx_bit   <= rx_bit + 1'b1;
            end
        end

    // parser, APB phase and response sequencing
    always_comb begin
        p_next = p_state;
        case (p_state)
            P_IDLE: if (rx_valid) p_next = (rx_shift == 8'h57 || rx_shift == 8'h52) ? P_ADDR : RESP;
            P_ADDR, P_DATA0, P_DATA1, P_DATA2, P_DATA3:
                if (rx_valid) p_next = (p_state == P_DATA3 || (p_state == P_ADDR && !pwrite)) ? APB_SETUP : p_state_t'(p_state + 4'd1);
                else if (rx_err || frame_to) p_next = P_IDLE;
            APB_SETUP:  p_next = APB_ACCESS;
            APB_ACCESS: if (pready || acc_to) p_next = RESP;
            RESP:       if (tx_bit_end && tx_bit == 4'd9 && tx_left == 3'd1) p_next = P_IDLE;
            default:    p_next = P_IDLE;
        endcase
    end

    // frame fields, saturating timeouts, response buffer and tx bit timing
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            pwrite   <= 1'b0;
            paddr    <= '0;
            pwdata   <= '0;
            to_cnt   <= '0;
            acc_cnt  <= '0;
            resp_buf <= '0;
            tx_left  <= '0;
            tx_cnt   <= '0;
            tx_bit   <= '0;
        end else begin
            to_cnt  <= (rx_valid || !in_frame) ? '0 : frame_to ? to_cnt : to_cnt + 1'b1;
            acc_cnt <= p_state != APB_ACCESS ? '0 : acc_to ? acc_cnt : acc_cnt + 1'b1;
            if (p_state == P_IDLE && rx_valid) begin
                if (rx_shift == 8'h57 || rx_shift == 8'h52) pwrite <= rx_shift == 8'h57;
                resp_buf <= {{APB_DATA_WIDTH{1'b0}}, 8'h3F};
                tx_left  <= 3'd1;
            end
            if (p_state == P_ADDR && rx_valid) paddr <= APB_ADDR_WIDTH'(rx_shift);
            if (p_state inside {P_DATA0, P_DATA1, P_DATA2, P_DATA3} && rx_valid)
                pwdata <= {rx_shift, pwdata[APB_DATA_WIDTH-1:8]};
            if (p_state == APB_ACCESS && (pready || acc_to)) begin
                resp_buf <= {prdata, !pready ? 8'h54 : pslverr ? 8'h45 : 8'h4B};
                tx_left  <= (pready && !pslverr && !pwrite) ? 3'd5 : 3'd1;
            end
            if (p_state == RESP) begin
                tx_cnt <= tx_bit_end ? '0 : tx_cnt + 1'b1;
                if (tx_bit_end) begin
                    tx_bit <= tx_bit == 4'd9 ? 4'd0 : tx_bit + 1'b1;
                    if (tx_bit == 4'd9) begin
                        resp_buf <= resp_buf >> 8;
                        tx_left  <= tx_left - 1'b1;
                    end
                end
            end else begin
                tx_cnt <= '0;
                tx_bit <= '0;
            end
        end
endmodule

// File: tb/tb_apb_uart_master.sv
// tb_apb_uart_master: randomized frames against a transaction-level scoreboard
module tb_apb_uart_master;
    localparam int CPB = 16;
    localparam int FTO = 400;
    localparam int PTO = 256;

    logic clk = 0, reset = 1, rx = 1;
    logic tx, psel, penable, pwrite, pready, pslverr, busy;
    logic [7:0] paddr;
    logic [31:0] pwdata, prdata;

    typedef struct {bit w; logic [7:0] a; logic [31:0] d; int pen;} apb_t;
    apb_t exp_apb[$];
    logic [7:0] exp_tx[$];
    int checks = 0, errors = 0;
    int cfg_wait = 0, acc_n = 0;
    bit cfg_err = 0, cfg_hang = 0;
    logic [31:0] cfg_rdata = 0;

    apb_uart_master #(.CLKS_PER_BIT(CPB), .APB_ADDR_WIDTH(8), .APB_DATA_WIDTH(32),
                      .FRAME_TIMEOUT(FTO), .PREADY_TIMEOUT(PTO)) dut (
        .clk(clk), .reset(reset), .rx(rx), .tx(tx), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr), .busy(busy));

    always #5 clk = ~clk;

    // slave model: pready after cfg_wait wait states unless hung
    always @(posedge clk) acc_n <= penable ? acc_n + 1 : 0;
    assign pready  = penable && !cfg_hang && acc_n == cfg_wait;
    assign prdata  = cfg_rdata;
    assign pslverr = cfg_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        rx = 0; repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin rx = b[i]; repeat (CPB) @(negedge clk); end
        rx = !bad_stop; repeat (CPB) @(negedge clk);
        rx = 1;
    endtask

    // reference model: one frame -> one APB transfer and its reply bytes
    task automatic do_xfer(input bit w, input logic [7:0] a, input logic [31:0] d,
                           input logic [31:0] rdata, input int waits, input bit err, input bit hang);
        apb_t e;
        logic [7:0] st;
        cfg_wait = waits; cfg_err = err; cfg_hang = hang; cfg_rdata = rdata;
        e.w = w; e.a = a; e.d = d; e.pen = hang ? PTO : waits + 1;
        exp_apb.push_back(e);
        st = hang ? 8'h54 : err ? 8'h45 : 8'h4B;
        exp_tx.push_back(st);
        if (!w && st == 8'h4B) for (int i = 0; i < 4; i++) exp_tx.push_back(rdata[8*i +: 8]);
        send_byte(w ? 8'h57 : 8'h52, 0);
        send_byte(a, 0);
        if (w) for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_tx.size() != 0) && n < 20000) begin @(negedge clk); n++; end
        if (n >= 20000) begin
            checks++; errors++;
            $display("FAIL idle_timeout actual=busy%0b/pending%0d required=idle", busy, exp_tx.size());
        end
        repeat (5) @(negedge clk);
    endtask

    // tx monitor: decode each 8N1 byte at mid-bit and compare with the next expected reply byte
    initial begin
        logic [7:0] b;
        logic s0, s9;
        forever begin
            @(negedge tx);
            if (!reset) begin
                repeat (CPB / 2) @(negedge clk);
                s0 = tx;
                for (int i = 0; i < 8; i++) begin repeat (CPB) @(negedge clk); b[i] = tx; end
                repeat (CPB) @(negedge clk);
                s9 = tx;
                if (exp_tx.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tx_unexpected actual=%h required=none", b);
                end else chk("tx_byte", {s0, b, s9}, {1'b0, exp_tx.pop_front(), 1'b1});
            end
        end
    end

    // APB monitor: collect one transfer from psel rise to fall, then compare with the model
    bit in_x = 0;
    initial begin
        apb_t e;
        logic w0, ok_setup, stable;
        logic [7:0] a0;
        logic [31:0] d0;
        int pen;
        forever begin
            @(negedge clk);
            if (reset) in_x = 0;
            else if (psel) begin
                if (!in_x) begin
                    in_x = 1; w0 = pwrite; a0 = paddr; d0 = pwdata; pen = 0;
                    ok_setup = !penable; stable = 1;
                end
                stable &= (pwrite == w0 && paddr == a0 && pwdata == d0);
                if (penable) pen++;
            end else if (in_x) begin
                in_x = 0;
                if (exp_apb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL apb_unexpected actual=addr%h required=none", a0);
                end else begin
                    e = exp_apb.pop_front();
                    chk("apb_dir", w0, e.w);
                    chk("apb_addr", a0, e.a);
                    if (e.w) chk("apb_wdata", d0, e.d);
                    chk("apb_penable_cycles", pen, e.pen);
                    chk("apb_setup_stable", {ok_setup, stable}, 2'b11);
                end
            end
        end
    end

    initial begin
        repeat (5) @(negedge clk);
        chk("reset_ctrl", {tx, psel, penable, pwrite, busy}, 5'b10000);
        chk("reset_paddr", paddr, 0);
        chk("reset_pwdata", pwdata, 0);
        reset = 0;
        repeat (5) @(negedge clk);

        do_xfer(1, 8'h10, 32'hDEADBEEF, 32'h0, 0, 0, 0); wait_idle();
        do_xfer(0, 8'h08, 32'h0, 32'h12345678, 3, 0, 0); wait_idle();
        do_xfer(1, 8'h20, 32'hCAFEF00D, 32'h0, 1, 1, 0); wait_idle();
        do_xfer(0, 8'h33, 32'h0, 32'h0BADF00D, 0, 0, 1); wait_idle();
        do_xfer(0, 8'h44, 32'h0, 32'hA5A55A5A, 0, 0, 0); wait_idle();

        exp_tx.push_back(8'h3F);
        send_byte(8'h41, 0); wait_idle();

        send_byte(8'h57, 0); wait_idle();
        do_xfer(0, 8'h55, 32'h0, 32'h01020304, 2, 0, 0); wait_idle();

        send_byte(8'h57, 0); send_byte(8'h10, 0); send_byte(8'hEF, 1);
        repeat (5) @(negedge clk);
        chk("ferr_abort_busy", busy, 0);
        wait_idle();
        do_xfer(1, 8'h66, 32'h89ABCDEF, 32'h0, 0, 0, 0); wait_idle();

        rx = 0; repeat (5) @(negedge clk); rx = 1;
        repeat (200) @(negedge clk);
        chk("glitch_busy", busy, 0);
        do_xfer(0, 8'h77, 32'h0, 32'hFEEDFACE, 1, 0, 0); wait_idle();

        cfg_hang = 1;
        send_byte(8'h52, 0); send_byte(8'h30, 0);
        for (int i = 0; i < 100 && !penable; i++) @(negedge clk);
        chk("reached_access", penable, 1);
        #2 reset = 1;
        #1 chk("async_reset_outs", {tx, psel, penable, busy}, 4'b1000);
        repeat (3) @(negedge clk);
        reset = 0; cfg_hang = 0;
        repeat (5) @(negedge clk);

        for (int k = 0; k < 25; k++) begin
            int kind = $urandom_range(0, 9);
            if (kind == 0) begin
                logic [7:0] b = 8'($urandom);
                if (b == 8'h57 || b == 8'h52) b = 8'h00;
                exp_tx.push_back(8'h3F);
                send_byte(b, 0);
            end else do_xfer(kind < 5, 8'($urandom), $urandom, $urandom,
                             $urandom_range(0, 5), $urandom_range(0, 3) == 0, 0);
            wait_idle();
        end

        chk("apb_queue_empty", exp_apb.size(), 0);
        chk("tx_queue_empty", exp_tx.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_uart_master.md
# apb_uart_master

UART-to-APB bridge: a host drives command frames over a serial link, and the block replays them as APB master transactions on the peripheral bus. It returns one status byte, plus read data, on its own TX line. It is the initiator counterpart of the APB UART peripherals and serves as the debug/bring-up access port into the APB fabric.

## Interface
- CLKS_PER_BIT, 434: clock cycles per UART bit, 8N1 framing (115200 baud at 50 MHz); minimum 8.
- APB_ADDR_WIDTH, 8: APB address width; one address byte per frame.
- APB_DATA_WIDTH, 32: APB data width; four data bytes per frame.
- FRAME_TIMEOUT, 1000000: maximum cycles between bytes of one frame.
- PREADY_TIMEOUT, 256: maximum ACCESS-phase cycles waiting for pready.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx  in  1  serial input; idles high. Passes through a 2-flop synchronizer before use.
- tx  out  1  serial output; idles high.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction; 1 = write.
- paddr  out  APB_ADDR_WIDTH  APB address.
- pwdata  out  APB_DATA_WIDTH  APB write data.
- prdata  in  APB_DATA_WIDTH  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.
- busy  out  1  high from the first byte of a frame until the last response bit is sent.

## Operation
- Reset values: tx=1, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, busy=0. All FSMs go to IDLE and all counters clear.
- RX framing:
  - A falling edge on the synchronized rx starts a byte. The start bit is re-checked at mid-bit; if rx is high there, the start is rejected and RX returns to idle.
  - Data bits are sampled at mid-bit, LSB first.
  - A stop bit sampled low is a framing error: the byte is discarded and the parser returns to P_IDLE with no response sent.
- Parser states: P_IDLE, P_ADDR, P_DATA0 to P_DATA3, APB_SETUP, APB_ACCESS, RESP.
  - P_IDLE, byte 0x57 ('W'): go to P_ADDR, pwrite=1.
  - P_IDLE, byte 0x52 ('R'): go to P_ADDR, pwrite=0.
  - P_IDLE, any other byte: send response 0x3F ('?').
  - P_ADDR: latch paddr. Go to P_DATA0 for a write, APB_SETUP for a read.
  - P_DATA0 to P_DATA3: latch pwdata little-endian, byte n into bits [8n+7:8n]. After P_DATA3, go to APB_SETUP.
  - Inter-byte timeout: if more than FRAME_TIMEOUT cycles pass between bytes in P_ADDR through P_DATA3, the frame is discarded and the parser returns to P_IDLE with no response.
  - Bytes completed while the parser is in APB_SETUP, APB_ACCESS or RESP are dropped.
- APB master:
  - APB_SETUP: psel=1, penable=0, for exactly one cycle.
  - APB_ACCESS: psel=1, penable=1, held until pready=1. On the pready cycle, capture prdata and pslverr; psel and penable deassert the next cycle.
  - paddr, pwrite and pwdata stay stable from SETUP through the end of ACCESS.
  - If pready has not been seen after PREADY_TIMEOUT ACCESS cycles, the transfer is aborted (psel and penable deassert) and the status is 0x54 ('T').
- Response bytes:
  - Status: 0x4B ('K') on success, 0x45 ('E') on pslverr=1, 0x54 ('T') on pready timeout.
  - A successful read sends 'K' followed by the captured prdata as four bytes, LSB first.
  - Writes, 'E' and 'T' responses send the status byte only.
- TX framing: 8N1, LSB first, each bit CLKS_PER_BIT cycles long. Consecutive response bytes are sent back-to-back with no extra idle time.
- busy drops, and the parser returns to P_IDLE, the cycle after the final stop bit ends.

## Timing
- RX byte-valid strobe: one cycle after the stop-bit mid-sample.
- Last frame byte to psel rise: 1 cycle.
- APB transfer length: 2 cycles plus wait states (cycles with pready=0).
- APB completion to TX start-bit low: 1 cycle.
- Write frame on the wire: 6 bytes in, 1 byte out.
- Read frame on the wire: 2 bytes in, 5 bytes out.
- An asserted reset takes effect asynchronously: psel and penable drop and tx goes high in the same instant, even mid-byte or mid-transfer.
- The timeout counters saturate; they do not wrap.

## Test plan
- Write frame 57 10 EF BE AD DE, pready tied to 1 -> one APB write with paddr=0x10, pwdata=0xDEADBEEF, SETUP then ACCESS of 1 cycle each; tx returns 0x4B.
- Read frame 52 08, prdata=0x12345678, 3 wait states -> penable high for 4 cycles; tx returns 4B 78 56 34 12.
- Write frame with pslverr=1 on the pready cycle -> tx returns 0x45 only.
- pready held at 0 -> 256 ACCESS cycles, then psel drops; tx returns 0x54; a following good read completes normally.
- Byte 0x41 -> tx returns 0x3F. Separately, byte 0x57 then silence longer than FRAME_TIMEOUT -> no response and no APB activity, and the next frame decodes correctly.
- Robustness: a byte with a bad stop bit mid-frame, a 0.3-bit glitch on rx, and reset asserted during APB_ACCESS -> no spurious transfer; outputs reach their reset values immediately.
